// File: rtl/mod_74x161_counter_pkg.sv
// Shared constants for the 74x161 counter slice and its cascade wrapper.
//   SLICE_W     : width of one 74x161 slice (4 bits)
//   TERM_COUNT  : all-ones terminal count of one slice
//   TPD_DEFAULT : default output propagation delay (timing build only)
package mod_74x161_counter_pkg;

  localparam int unsigned SLICE_W     = 4;
  localparam logic [SLICE_W-1:0] TERM_COUNT = '1;
  localparam int unsigned TPD_DEFAULT = 1;

endpackage : mod_74x161_counter_pkg

// File: rtl/mod_74x161_slice.sv
// One 4-bit 74x161 slice: synchronous load/count, asynchronous clear.
// Ports:
//   CLK    in  1  rising-edge clock
//   CLR_N  in  1  asynchronous clear, active-low
//   LOAD_N in  1  synchronous parallel load, active-low (beats count)
//   ENP    in  1  count enable P
//   ENT    in  1  count enable T, also gates RCO
//   D      in  4  parallel load data
//   Q      out 4  counter value
//   RCO    out 1  ripple carry out = ENT & (Q == 4'hF), combinational
// Optional feature macro: MOD_74X161_TIMING_EN adds #TPD inertial delay on Q and RCO.
module mod_74x161_slice
  import mod_74x161_counter_pkg::*;
#(
  parameter int unsigned TPD = TPD_DEFAULT
) (
  input  logic               CLK,
  input  logic               CLR_N,
  input  logic               LOAD_N,
  input  logic               ENP,
  input  logic               ENT,
  input  logic [SLICE_W-1:0] D,
  output logic [SLICE_W-1:0] Q,
  output logic               RCO
);

  logic [SLICE_W-1:0] q_r;
  logic [SLICE_W-1:0] q_nxt;
  logic               ctl_x;
  logic               rco_c;

  // Next-state: load beats count, otherwise hold.
  always_comb begin
    q_nxt = q_r;
    // Zero for known controls; X in 4-state simulation when any control is X/Z,
    // so an unknown control corrupts Q instead of silently picking a branch.
    ctl_x = (LOAD_N ^ LOAD_N) | (ENP ^ ENP) | (ENT ^ ENT);
    if (!LOAD_N) begin
      q_nxt = D;
    end else if (ENP & ENT) begin
      q_nxt = q_r + SLICE_W'(1);
    end
    q_nxt = q_nxt ^ {SLICE_W{ctl_x}};
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      q_r <= '0;
    end else begin
      q_r <= q_nxt;
    end
  end

  // Terminal-count carry, independent of ENP/LOAD_N/CLK.
  assign rco_c = ENT & (q_r == TERM_COUNT);

`ifdef MOD_74X161_TIMING_EN
  assign #(TPD) Q   = q_r;
  assign #(TPD) RCO = rco_c;
`else
  logic unused_tpd;
  assign unused_tpd = |32'(TPD);
  assign Q   = q_r;
  assign RCO = rco_c;
`endif

endmodule : mod_74x161_slice

// File: rtl/mod_74x161_counter.sv
// Presettable binary counter built from SLICES cascaded 74x161 slices.
// Ports:
//   CLK    in  1  rising-edge clock (shared by all slices)
//   CLR_N  in  1  asynchronous clear, active-low (shared)
//   LOAD_N in  1  synchronous parallel load, active-low (shared)
//   ENP    in  1  count enable P (shared, not propagated to RCO)
//   ENT    in  1  count enable T into slice 0
//   D      in  W  parallel load data, bit 0 = LSB, W = 4*SLICES
//   Q      out W  counter value
//   RCO    out 1  ripple carry of the most significant slice
// Optional feature macro: MOD_74X161_TIMING_EN (per-slice #TPD output delay).
module mod_74x161_counter
  import mod_74x161_counter_pkg::*;
#(
  parameter int unsigned SLICES = 1,
  parameter int unsigned TPD    = TPD_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        CLR_N,
  input  logic                        LOAD_N,
  input  logic                        ENP,
  input  logic                        ENT,
  input  logic [SLICE_W*SLICES-1:0]   D,
  output logic [SLICE_W*SLICES-1:0]   Q,
  output logic                        RCO
);

  localparam int unsigned W = SLICE_W * SLICES;

  // ent_chain[i] is ENT of slice i; ent_chain[i+1] is its RCO.
  logic [SLICES:0] ent_chain;

  assign ent_chain[0] = ENT;

  // Datasheet cascade: each slice counts only when all lower slices are at terminal count.
  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    mod_74x161_slice #(
      .TPD (TPD)
    ) u_slice (
      .CLK    (CLK),
      .CLR_N  (CLR_N),
      .LOAD_N (LOAD_N),
      .ENP    (ENP),
      .ENT    (ent_chain[i]),
      .D      (D[i*SLICE_W +: SLICE_W]),
      .Q      (Q[i*SLICE_W +: SLICE_W]),
      .RCO    (ent_chain[i+1])
    );
  end

  assign RCO = ent_chain[SLICES];

  logic unused_w;
  assign unused_w = |32'(W);

endmodule : mod_74x161_counter

// File: tb/tb_mod_74x161_counter.sv
module tb_mod_74x161_counter;

  logic       clk;
  logic       clr_n;
  logic       load_n;
  logic       enp;
  logic       ent;
  logic [3:0] d1;
  logic [3:0] q1;
  logic       rco1;
  logic [7:0] d2;
  logic [7:0] q2;
  logic       rco2;

  int n_chk;
  int n_pass;

  // Reference model: plain integer counters modulo 2^W.
  int mq1;
  int mq2;

  mod_74x161_counter #(.SLICES(1)) u_dut1 (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(load_n), .ENP(enp), .ENT(ent),
    .D(d1), .Q(q1), .RCO(rco1)
  );

  mod_74x161_counter #(.SLICES(2)) u_dut2 (
    .CLK(clk), .CLR_N(clr_n), .LOAD_N(load_n), .ENP(enp), .ENT(ent),
    .D(d2), .Q(q2), .RCO(rco2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One rising edge; model follows the behavioural rules, then settle past the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!clr_n) begin
      mq1 = 0;
      mq2 = 0;
    end else if (!load_n) begin
      mq1 = int'(d1);
      mq2 = int'(d2);
    end else if (enp && ent) begin
      mq1 = (mq1 + 1) % 16;
      mq2 = (mq2 + 1) % 256;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; d1 = 4'h0; d2 = 8'h00;
    mq1 = 0; mq2 = 0;
    #1;
    n_chk++;
    if (q1 !== 4'h0) $display("FAIL reset_q: got %h expected %h", q1, 4'h0); else n_pass++;
    @(negedge clk); #1;
    clr_n = 1'b1; load_n = 1'b0; d1 = 4'hA; d2 = 8'hA5;
    tick();
    n_chk++;
    if (q1 !== 4'hA) $display("FAIL preload_a: got %h expected %h", q1, 4'hA); else n_pass++;
    // Clear between edges with clock otherwise idle from the counter's point of view.
    load_n = 1'b1;
    #1 clr_n = 1'b0;
    #1;
    mq1 = 0; mq2 = 0;
    n_chk++;
    if (q1 !== 4'h0) $display("FAIL async_clear_q: got %h expected %h", q1, 4'h0); else n_pass++;
    n_chk++;
    if (rco1 !== 1'b0) $display("FAIL async_clear_rco: got %b expected %b", rco1, 1'b0); else n_pass++;
    n_chk++;
    if (q2 !== 8'h00) $display("FAIL async_clear_q2: got %h expected %h", q2, 8'h00); else n_pass++;
    tick();
    n_chk++;
    if (q1 !== 4'h0) $display("FAIL clear_held: got %h expected %h", q1, 4'h0); else n_pass++;
    clr_n = 1'b1;
  endtask

  task automatic test_load();
    load_n = 1'b0; d1 = 4'h9; enp = 1'b0; ent = 1'b0;
    tick();
    n_chk++;
    if (q1 !== 4'h9) $display("FAIL load_9: got %h expected %h", q1, 4'h9); else n_pass++;
    d1 = 4'h3; enp = 1'b1; ent = 1'b1;
    tick();
    n_chk++;
    if (q1 !== 4'h3) $display("FAIL load_beats_count: got %h expected %h", q1, 4'h3); else n_pass++;
  endtask

  task automatic test_count_hold();
    load_n = 1'b1; enp = 1'b1; ent = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_chk++;
    if (q1 !== 4'h6) $display("FAIL count_3: got %h expected %h", q1, 4'h6); else n_pass++;
    enp = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    n_chk++;
    if (q1 !== 4'h6) $display("FAIL hold_enp: got %h expected %h", q1, 4'h6); else n_pass++;
    enp = 1'b1; ent = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    n_chk++;
    if (q1 !== 4'h6) $display("FAIL hold_ent: got %h expected %h", q1, 4'h6); else n_pass++;
  endtask

  task automatic test_wrap_rco();
    load_n = 1'b0; d1 = 4'hF; enp = 1'b0; ent = 1'b0;
    tick();
    load_n = 1'b1; ent = 1'b1;
    #1;
    n_chk++;
    if (rco1 !== 1'b1) $display("FAIL rco_at_tc: got %b expected %b", rco1, 1'b1); else n_pass++;
    ent = 1'b0;
    #1;
    n_chk++;
    if (rco1 !== 1'b0) $display("FAIL rco_ent_low: got %b expected %b", rco1, 1'b0); else n_pass++;
    ent = 1'b1; enp = 1'b1;
    tick();
    n_chk++;
    if (q1 !== 4'h0) $display("FAIL wrap_q: got %h expected %h", q1, 4'h0); else n_pass++;
    n_chk++;
    if (rco1 !== 1'b0) $display("FAIL wrap_rco: got %b expected %b", rco1, 1'b0); else n_pass++;
  endtask

  task automatic test_cascade();
    load_n = 1'b0; d2 = 8'h0F; enp = 1'b1; ent = 1'b1;
    tick();
    load_n = 1'b1;
    tick();
    n_chk++;
    if (q2 !== 8'h10) $display("FAIL cascade_carry: got %h expected %h", q2, 8'h10); else n_pass++;
    load_n = 1'b0; d2 = 8'hFF;
    tick();
    load_n = 1'b1;
    #1;
    n_chk++;
    if (rco2 !== 1'b1) $display("FAIL cascade_rco_tc: got %b expected %b", rco2, 1'b1); else n_pass++;
    tick();
    n_chk++;
    if (q2 !== 8'h00) $display("FAIL cascade_wrap: got %h expected %h", q2, 8'h00); else n_pass++;
    n_chk++;
    if (rco2 !== 1'b0) $display("FAIL cascade_wrap_rco: got %b expected %b", rco2, 1'b0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    load_n = 1'b0; d1 = 4'h5; d2 = 8'h55; enp = 1'b1; ent = 1'b1;
    tick();
    load_n = 1'b1;
    #1 clr_n = 1'b0;
    #1;
    mq1 = 0; mq2 = 0;
    n_chk++;
    if (q1 !== 4'h0) $display("FAIL mid_clear: got %h expected %h", q1, 4'h0); else n_pass++;
    #1 clr_n = 1'b1;
    tick();
    n_chk++;
    if (q1 !== 4'h1) $display("FAIL after_clear_count: got %h expected %h", q1, 4'h1); else n_pass++;
    n_chk++;
    if (q2 !== 8'h01) $display("FAIL after_clear_count2: got %h expected %h", q2, 8'h01); else n_pass++;
  endtask

  task automatic test_random();
    // Resynchronise model with the DUT state reached by the directed tests via a load.
    load_n = 1'b0; d1 = 4'h0; d2 = 8'h00;
    tick();
    for (int i = 0; i < 300; i++) begin
      load_n = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      enp    = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      ent    = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      d1     = 4'($urandom);
      d2     = 8'($urandom_range(0, 1) == 0 ? $urandom_range(240, 255) : $urandom);
      #1;
      n_chk++;
      if (rco1 !== (ent && mq1 == 15))
        $display("FAIL rand_rco1 i=%0d: got %b expected %b", i, rco1, (ent && mq1 == 15));
      else n_pass++;
      n_chk++;
      if (rco2 !== (ent && mq2 == 255))
        $display("FAIL rand_rco2 i=%0d: got %b expected %b", i, rco2, (ent && mq2 == 255));
      else n_pass++;
      tick();
      n_chk++;
      if (int'(q1) !== mq1) $display("FAIL rand_q1 i=%0d: got %0d expected %0d", i, q1, mq1); else n_pass++;
      n_chk++;
      if (int'(q2) !== mq2) $display("FAIL rand_q2 i=%0d: got %0d expected %0d", i, q2, mq2); else n_pass++;
      if ($urandom_range(0, 19) == 0) begin
        clr_n = 1'b0;
        #1;
        mq1 = 0; mq2 = 0;
        n_chk++;
        if (q2 !== 8'h00) $display("FAIL rand_clear i=%0d: got %h expected %h", i, q2, 8'h00); else n_pass++;
        clr_n = 1'b1;
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_load();
    test_count_hold();
    test_wrap_rco();
    test_cascade();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_mod_74x161_counter
